// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw button levels and frame strobe in,
// conditioned key levels, edge pulses and frame snapshots out.
interface key_conditioner_if #(
    parameter int KEYS_W = 4
);
    logic [KEYS_W-1:0] keys_i;
    logic              new_frame_i;
    logic [KEYS_W-1:0] keys_o;
    logic [KEYS_W-1:0] press_o;
    logic [KEYS_W-1:0] release_o;
    logic [KEYS_W-1:0] keys_frame_o;
    logic [KEYS_W-1:0] taps_frame_o;

    modport master (
        output keys_i,
        output new_frame_i,
        input  keys_o,
        input  press_o,
        input  release_o,
        input  keys_frame_o,
        input  taps_frame_o
    );

    modport slave (
        input  keys_i,
        input  new_frame_i,
        output keys_o,
        output press_o,
        output release_o,
        output keys_frame_o,
        output taps_frame_o
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button front end: per-key two-flop synchroniser, debounce counter,
// press/release pulses, and frame-aligned level and tap snapshots.
module key_conditioner #(
    parameter int KEYS_W          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int KEYS_ACTIVE_LOW = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    key_conditioner_if.slave    kif
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [KEYS_W-1:0] INV_MASK = (KEYS_ACTIVE_LOW != 0) ? '1 : '0;

    logic [KEYS_W-1:0] raw;
    logic [KEYS_W-1:0] q1;
    logic [KEYS_W-1:0] q2;
    logic [KEYS_W-1:0] d;
    logic [KEYS_W-1:0] d_next;
    logic [CNT_W-1:0]  cnt      [KEYS_W];
    logic [CNT_W-1:0]  cnt_next [KEYS_W];
    logic [KEYS_W-1:0] press_q;
    logic [KEYS_W-1:0] press_next;
    logic [KEYS_W-1:0] release_q;
    logic [KEYS_W-1:0] release_next;
    logic [KEYS_W-1:0] acc;
    logic [KEYS_W-1:0] keys_frame_q;
    logic [KEYS_W-1:0] taps_frame_q;

    assign raw = kif.keys_i ^ INV_MASK;

    // Two-flop synchroniser on the normalised (1 = pressed) levels.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= raw;
            q2 <= q1;
        end
    end

    // Per-key debounce decision: accept a change after DEBOUNCE_CYCLES stable cycles.
    always_comb begin
        d_next       = d;
        press_next   = '0;
        release_next = '0;
        for (int unsigned k = 0; k < KEYS_W; k++) begin
            cnt_next[k] = '0;
            if (q2[k] != d[k]) begin
                if (cnt[k] == CNT_LAST) begin
                    d_next[k]       = q2[k];
                    press_next[k]   = q2[k];
                    release_next[k] = ~q2[k];
                end else begin
                    cnt_next[k] = cnt[k] + 1'b1;
                end
            end
        end
    end

    // Debounce state, counters and one-cycle edge pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            d         <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned k = 0; k < KEYS_W; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            d         <= d_next;
            press_q   <= press_next;
            release_q <= release_next;
            for (int unsigned k = 0; k < KEYS_W; k++) begin
                cnt[k] <= cnt_next[k];
            end
        end
    end

    // Frame snapshots and tap accumulator.
    // The accumulator collects acceptances as they happen (press_next), so an
    // acceptance on a strobe edge lands in that strobe's taps, and the press_o
    // pulse that follows is already accounted for and cannot leak into the
    // next window.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc          <= '0;
            keys_frame_q <= '0;
            taps_frame_q <= '0;
        end else if (kif.new_frame_i) begin
            keys_frame_q <= d;
            taps_frame_q <= acc | press_next;
            acc          <= '0;
        end else begin
            acc <= acc | press_next;
        end
    end

    assign kif.keys_o       = d;
    assign kif.press_o      = press_q;
    assign kif.release_o    = release_q;
    assign kif.keys_frame_o = keys_frame_q;
    assign kif.taps_frame_o = taps_frame_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, active-low keys.
module tb_key_conditioner;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    key_conditioner_if #(.KEYS_W(4)) kif ();

    key_conditioner #(
        .KEYS_W         (4),
        .DEBOUNCE_CYCLES(4),
        .KEYS_ACTIVE_LOW(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .kif  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_keys"},  kif.keys_o,       4'b0000);
        chk({tag, "_press"}, kif.press_o,      4'b0000);
        chk({tag, "_rel"},   kif.release_o,    4'b0000);
        chk({tag, "_kfr"},   kif.keys_frame_o, 4'b0000);
        chk({tag, "_tfr"},   kif.taps_frame_o, 4'b0000);
    endtask

    task automatic strobe();
        kif.new_frame_i = 1'b1;
        tick();
        kif.new_frame_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 1: reset, all keys released (high), outputs zero before any edge
        rst_n           = 1'b0;
        kif.keys_i      = 4'b1111;
        kif.new_frame_i = 1'b0;
        #2;
        chk_all_zero("rst_async");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all_zero("rst_hold");
        end

        // 2: key 0 pressed; capture at edge 1, accepted at edge 6
        kif.keys_i = 4'b1110;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("s2_keys_pre", kif.keys_o, 4'b0000);
            chk("s2_press_pre", kif.press_o, 4'b0000);
        end
        tick();
        chk("s2_keys_acc", kif.keys_o, 4'b0001);
        chk("s2_press_acc", kif.press_o, 4'b0001);
        tick();
        chk("s2_keys_post", kif.keys_o, 4'b0001);
        chk("s2_press_post", kif.press_o, 4'b0000);

        // 3: key 1 bounces low 3 / high 3 cycles, never accepted
        for (int r = 0; r < 5; r++) begin
            kif.keys_i = 4'b1100;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("s3_keys", kif.keys_o & 4'b0010, 4'b0000);
                chk("s3_press", kif.press_o & 4'b0010, 4'b0000);
                chk("s3_rel", kif.release_o & 4'b0010, 4'b0000);
            end
            kif.keys_i = 4'b1110;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("s3_keys", kif.keys_o & 4'b0010, 4'b0000);
                chk("s3_press", kif.press_o & 4'b0010, 4'b0000);
                chk("s3_rel", kif.release_o & 4'b0010, 4'b0000);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s3_settle", kif.keys_o, 4'b0001);
        end

        // 4: key 2 press, accept, then release and release pulse at edge 6
        kif.keys_i = 4'b1010;
        for (int i = 0; i < 5; i++) tick();
        chk("s4_keys_pre", kif.keys_o, 4'b0001);
        tick();
        chk("s4_keys_acc", kif.keys_o, 4'b0101);
        chk("s4_press", kif.press_o, 4'b0100);
        tick();
        tick();
        kif.keys_i = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s4_rel_pre", kif.release_o, 4'b0000);
            chk("s4_keys_held", kif.keys_o, 4'b0101);
        end
        tick();
        chk("s4_rel", kif.release_o, 4'b0100);
        chk("s4_keys_rel", kif.keys_o, 4'b0001);
        tick();
        chk("s4_rel_post", kif.release_o, 4'b0000);

        // 5: tap key 3 inside a 40-cycle frame window
        strobe();
        kif.keys_i = 4'b0110;
        for (int i = 0; i < 8; i++) tick();
        chk("s5_keys_tap", kif.keys_o, 4'b1001);
        kif.keys_i = 4'b1110;
        for (int i = 0; i < 31; i++) tick();
        chk("s5_keys_after", kif.keys_o, 4'b0001);
        strobe();
        chk("s5_taps", kif.taps_frame_o, 4'b1000);
        chk("s5_kfr", kif.keys_frame_o, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s5_taps_hold", kif.taps_frame_o, 4'b1000);
        end
        for (int i = 0; i < 19; i++) tick();
        strobe();
        chk("s5_taps_next", kif.taps_frame_o, 4'b0000);
        chk("s5_kfr_next", kif.keys_frame_o, 4'b0001);

        // 6: strobe on the same edge as key 0 press acceptance
        kif.keys_i = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        chk("s6_released", kif.keys_o, 4'b0000);
        strobe();
        kif.keys_i = 4'b1110;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_keys_pre", kif.keys_o, 4'b0000);
        strobe();
        chk("s6_keys", kif.keys_o, 4'b0001);
        chk("s6_press", kif.press_o, 4'b0001);
        chk("s6_kfr", kif.keys_frame_o, 4'b0000);
        chk("s6_taps", kif.taps_frame_o, 4'b0001);
        strobe();
        chk("s6_taps_b2b", kif.taps_frame_o, 4'b0000);
        chk("s6_kfr_b2b", kif.keys_frame_o, 4'b0001);

        // 7: reset mid-operation with key 0 held; re-accepted after DEBOUNCE+2
        kif.keys_i = 4'b1010;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("s7_rst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s7_keys_pre", kif.keys_o, 4'b0000);
        end
        tick();
        chk("s7_keys", kif.keys_o, 4'b0101);
        chk("s7_press", kif.press_o, 4'b0101);
        tick();
        chk("s7_press_post", kif.press_o, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
